// File: rtl/yonga_can_pkg.sv
// Shared register map, status codes, scheduler states and mailbox payload type
// for the CAN TX mailbox register block.
package yonga_can_pkg;

    localparam int unsigned REG_BAUD     = 32'h00;
    localparam int unsigned REG_SYS_CFG  = 32'h04;
    localparam int unsigned REG_CTRL_STS = 32'h08;
    localparam int unsigned REG_IRQ_STS  = 32'h0C;
    localparam int unsigned REG_TX_REQ   = 32'h10;
    localparam int unsigned REG_TX_ABORT = 32'h14;
    localparam int unsigned MBOX_BASE    = 32'h20;
    localparam int unsigned MBOX_STRIDE  = 32'h10;

    localparam int unsigned SYS_CFG_EN   = 1;
    localparam int unsigned SYS_IRQ_EN   = 2;
    localparam int unsigned SYS_ARB_MODE = 3;

    localparam logic [2:0] STS_OK       = 3'b001;
    localparam logic [2:0] STS_ARB_LOST = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [31:0] id;
        logic [31:0] cfg;
        logic [31:0] data1;
        logic [31:0] data2;
    } mbox_t;

    // Merge new_val into old_val one byte lane per strobe bit.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/yonga_can_mbox_arbiter.sv
// Combinational mailbox arbiter: fixed priority (lowest index) or round-robin
// starting at rr_ptr. The pointer register lives in the parent.
module yonga_can_mbox_arbiter
    import yonga_can_pkg::*;
#(
    parameter int unsigned NUM_MBOX = 4
) (
    input  logic [NUM_MBOX-1:0] pending,
    input  logic                arb_mode,
    input  logic [2:0]          rr_ptr,
    output logic [2:0]          grant_idx,
    output logic                grant_valid
);

    int unsigned         cand;
    logic [NUM_MBOX-1:0] shifted;

    always_comb begin
        grant_idx   = 3'd0;
        grant_valid = 1'b0;
        cand        = 0;
        shifted     = '0;
        for (int unsigned i = 0; i < NUM_MBOX; i++) begin
            cand    = arb_mode ? (32'(rr_ptr) + i) % NUM_MBOX : i;
            shifted = pending >> cand;
            if (!grant_valid && shifted[0]) begin
                grant_valid = 1'b1;
                grant_idx   = 3'(cand);
            end
        end
    end

endmodule

// File: rtl/yonga_can_tx_mbox_regs.sv
// CPU register file plus TX mailbox scheduler for the CAN peripheral: holds
// NUM_MBOX mailboxes and hands one at a time to the CAN controller.
module yonga_can_tx_mbox_regs
    import yonga_can_pkg::*;
#(
    parameter int unsigned BITS     = 32,
    parameter int unsigned NUM_MBOX = 4,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    output logic              ready,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BITS-1:0]   wdata,
    input  logic [3:0]        wstrb,
    output logic [BITS-1:0]   rdata,
    output logic [26:0]       baud_cfg,
    output logic              cfg_en,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic              tx_done,
    input  logic [2:0]        tx_sts,
    output logic [10:0]       tx_sid,
    output logic              tx_ide,
    output logic [17:0]       tx_eid,
    output logic              tx_rtr,
    output logic [3:0]        tx_dlc,
    output logic [63:0]       tx_data,
    output logic              irq
);

    localparam int unsigned IDX_W = (NUM_MBOX > 1) ? $clog2(NUM_MBOX) : 1;

    sched_state_e        state_q, state_d;
    logic [NUM_MBOX-1:0] pending_q, pending_d;
    logic [NUM_MBOX-1:0] done_q, done_d;
    logic [NUM_MBOX-1:0] err_q, err_d;
    logic [2:0]          active_q, active_d;
    logic [2:0]          rr_ptr_q, rr_ptr_d;
    logic [2:0]          last_sts_q, last_sts_d;
    logic [26:0]         baud_q, baud_d;
    logic                cfg_en_q, cfg_en_d;
    logic                irq_en_q, irq_en_d;
    logic                arb_mode_q, arb_mode_d;
    mbox_t               mbox_q [NUM_MBOX];
    mbox_t               mbox_d [NUM_MBOX];
    mbox_t               txm_q, txm_d;
    logic                ready_q, ready_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                tx_start_q, tx_start_d;
    logic                irq_q, irq_d;

    logic                access, wr, aligned, busy, in_mbox, mb_locked;
    logic [IDX_W-1:0]    mb_idx, act_idx;
    logic [1:0]          mb_word;
    logic [NUM_MBOX-1:0] active_mask, bus_mask;
    logic [31:0]         rd_val;
    logic [2:0]          grant_idx;
    logic                grant_valid;

    yonga_can_mbox_arbiter #(.NUM_MBOX(NUM_MBOX)) u_arb (
        .pending     (pending_q),
        .arb_mode    (arb_mode_q),
        .rr_ptr      (rr_ptr_q),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Address decode and mailbox write protection.
    assign access      = valid && !ready_q;
    assign aligned     = (addr[1:0] == 2'b00);
    assign wr          = access && we && aligned;
    assign busy        = (state_q != ST_IDLE);
    assign in_mbox     = (32'(addr) >= MBOX_BASE) &&
                         (32'(addr) < MBOX_BASE + MBOX_STRIDE * NUM_MBOX);
    assign mb_idx      = IDX_W'((32'(addr) - MBOX_BASE) / MBOX_STRIDE);
    assign mb_word     = addr[3:2];
    assign act_idx     = IDX_W'(active_q);
    assign active_mask = busy ? (NUM_MBOX'(1) << act_idx) : '0;
    assign bus_mask    = wdata[NUM_MBOX-1:0] & ~active_mask;
    assign mb_locked   = pending_q[mb_idx] || (busy && (act_idx == mb_idx));

    // Read mux.
    always_comb begin
        rd_val = '0;
        if (aligned) begin
            if (in_mbox) begin
                case (mb_word)
                    2'd0:    rd_val = mbox_q[mb_idx].id;
                    2'd1:    rd_val = mbox_q[mb_idx].cfg;
                    2'd2:    rd_val = mbox_q[mb_idx].data1;
                    default: rd_val = mbox_q[mb_idx].data2;
                endcase
            end else begin
                case (32'(addr))
                    REG_BAUD:    rd_val = 32'(baud_q);
                    REG_SYS_CFG: rd_val = {28'd0, arb_mode_q, irq_en_q, cfg_en_q, 1'b0};
                    REG_CTRL_STS: begin
                        rd_val[NUM_MBOX-1:0] = pending_q;
                        rd_val[10:8]         = last_sts_q;
                        rd_val[14:12]        = active_q;
                        rd_val[15]           = busy;
                    end
                    REG_IRQ_STS: begin
                        rd_val[NUM_MBOX-1:0] = done_q;
                        rd_val[8 +: NUM_MBOX] = err_q;
                    end
                    REG_TX_REQ:  rd_val[NUM_MBOX-1:0] = pending_q;
                    default:     rd_val = '0;
                endcase
            end
        end
    end

    // Next-state: bus writes first, scheduler afterwards so hardware sets win.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        done_d     = done_q;
        err_d      = err_q;
        active_d   = active_q;
        rr_ptr_d   = rr_ptr_q;
        last_sts_d = last_sts_q;
        baud_d     = baud_q;
        cfg_en_d   = cfg_en_q;
        irq_en_d   = irq_en_q;
        arb_mode_d = arb_mode_q;
        mbox_d     = mbox_q;
        txm_d      = txm_q;
        tx_start_d = 1'b0;
        ready_d    = access;
        rdata_d    = (access && !we) ? rd_val : '0;
        irq_d      = irq_en_q && ((|done_q) || (|err_q));

        if (wr && in_mbox && !mb_locked) begin
            case (mb_word)
                2'd0:    mbox_d[mb_idx].id    = apply_strb(mbox_q[mb_idx].id, wdata, wstrb);
                2'd1:    mbox_d[mb_idx].cfg   = apply_strb(mbox_q[mb_idx].cfg, wdata, wstrb);
                2'd2:    mbox_d[mb_idx].data1 = apply_strb(mbox_q[mb_idx].data1, wdata, wstrb);
                default: mbox_d[mb_idx].data2 = apply_strb(mbox_q[mb_idx].data2, wdata, wstrb);
            endcase
        end else if (wr && !in_mbox) begin
            case (32'(addr))
                REG_BAUD: if (cfg_en_q) baud_d = 27'(apply_strb(32'(baud_q), wdata, wstrb));
                REG_SYS_CFG: if (wstrb[0]) begin
                    cfg_en_d   = wdata[SYS_CFG_EN];
                    irq_en_d   = wdata[SYS_IRQ_EN];
                    arb_mode_d = wdata[SYS_ARB_MODE];
                end
                REG_IRQ_STS: begin
                    done_d = done_q & ~wdata[NUM_MBOX-1:0];
                    err_d  = err_q & ~wdata[8 +: NUM_MBOX];
                end
                REG_TX_REQ:   pending_d = pending_q | bus_mask;
                REG_TX_ABORT: pending_d = pending_q & ~bus_mask;
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (!cfg_en_q && (|pending_q) && !tx_busy && grant_valid) begin
                    state_d    = ST_START;
                    active_d   = grant_idx;
                    txm_d      = mbox_q[IDX_W'(grant_idx)];
                    tx_start_d = 1'b1;
                end
            end
            ST_START: state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    last_sts_d = tx_sts;
                    rr_ptr_d   = (32'(active_q) == NUM_MBOX - 1) ? 3'd0 : active_q + 3'd1;
                    if (tx_sts == STS_OK) begin
                        pending_d[act_idx] = 1'b0;
                        done_d[act_idx]    = 1'b1;
                    end else if (tx_sts != STS_ARB_LOST) begin
                        pending_d[act_idx] = 1'b0;
                        err_d[act_idx]     = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            done_q     <= '0;
            err_q      <= '0;
            active_q   <= '0;
            rr_ptr_q   <= '0;
            last_sts_q <= '0;
            baud_q     <= '0;
            cfg_en_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            arb_mode_q <= 1'b0;
            for (int i = 0; i < NUM_MBOX; i++) mbox_q[i] <= '0;
            txm_q      <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            tx_start_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            done_q     <= done_d;
            err_q      <= err_d;
            active_q   <= active_d;
            rr_ptr_q   <= rr_ptr_d;
            last_sts_q <= last_sts_d;
            baud_q     <= baud_d;
            cfg_en_q   <= cfg_en_d;
            irq_en_q   <= irq_en_d;
            arb_mode_q <= arb_mode_d;
            for (int i = 0; i < NUM_MBOX; i++) mbox_q[i] <= mbox_d[i];
            txm_q      <= txm_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            tx_start_q <= tx_start_d;
            irq_q      <= irq_d;
        end
    end

    assign ready    = ready_q;
    assign rdata    = rdata_q;
    assign baud_cfg = baud_q;
    assign cfg_en   = cfg_en_q;
    assign tx_start = tx_start_q;
    assign irq      = irq_q;
    assign tx_sid   = txm_q.id[29:19];
    assign tx_ide   = txm_q.id[18];
    assign tx_eid   = txm_q.id[17:0];
    assign tx_rtr   = txm_q.cfg[4];
    assign tx_dlc   = txm_q.cfg[3:0];
    assign tx_data  = {txm_q.data2, txm_q.data1};

endmodule

// File: tb/tb_yonga_can_tx_mbox_regs.sv
// Directed bench for yonga_can_tx_mbox_regs: bus reads and mailbox launches are
// checked against scoreboard queues filled when the stimulus is issued.
module tb_yonga_can_tx_mbox_regs;

    logic        clk, rst, valid, ready, we;
    logic [7:0]  addr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [26:0] baud_cfg;
    logic        cfg_en, tx_start, tx_busy, tx_done;
    logic [2:0]  tx_sts;
    logic [10:0] tx_sid;
    logic        tx_ide;
    logic [17:0] tx_eid;
    logic        tx_rtr;
    logic [3:0]  tx_dlc;
    logic [63:0] tx_data;
    logic        irq;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q [$];
    logic [10:0] obs_q [$];
    int          launch_q [$];
    logic [31:0] m_id [4], m_cfg [4], m_d1 [4], m_d2 [4];

    yonga_can_tx_mbox_regs #(.BITS(32), .NUM_MBOX(4), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .valid(valid), .ready(ready), .we(we),
        .addr(addr), .wdata(wdata), .wstrb(wstrb), .rdata(rdata),
        .baud_cfg(baud_cfg), .cfg_en(cfg_en), .tx_start(tx_start),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_sts(tx_sts),
        .tx_sid(tx_sid), .tx_ide(tx_ide), .tx_eid(tx_eid), .tx_rtr(tx_rtr),
        .tx_dlc(tx_dlc), .tx_data(tx_data), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record the SID of every launch pulse the controller would see.
    always @(negedge clk) begin
        if (tx_start === 1'b1) obs_q.push_back(tx_sid);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
        @(negedge clk);
        check("ready_idle", 64'(ready), 64'd0);
        valid = 1'b1; we = w; addr = a; wdata = d; wstrb = s;
        @(negedge clk);
        check("ready_ack", 64'(ready), 64'd1);
        rd = rdata;
        valid = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] unused_rd;
        bus(1'b1, a, d, 4'hF, unused_rd);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] e);
        logic [31:0] v;
        exp_q.push_back(e);
        bus(1'b0, a, 32'd0, 4'h0, v);
        check(tag, 64'(v), 64'(exp_q.pop_front()));
    endtask

    task automatic wr_mbox(input int n, input logic [31:0] id, input logic [31:0] cf,
                           input logic [31:0] d1, input logic [31:0] d2);
        logic [7:0] base;
        base = 8'(32'h20 + 16 * n);
        wr(base, id); wr(base + 8'h4, cf); wr(base + 8'h8, d1); wr(base + 8'hC, d2);
        m_id[n] = id; m_cfg[n] = cf; m_d1[n] = d1; m_d2[n] = d2;
    endtask

    // Pop the next expected launch and compare against the observed SID.
    task automatic wait_launch(input string tag);
        int          idx;
        int          n;
        logic [31:0] id;
        n   = 0;
        idx = launch_q.pop_front();
        id  = m_id[idx];
        while (obs_q.size() == 0 && n < 40) begin
            @(negedge clk); #1; n++;
        end
        if (obs_q.size() == 0) check({tag, "_timeout"}, 64'd0, 64'd1);
        else check(tag, 64'(obs_q.pop_front()), 64'(id[29:19]));
    endtask

    task automatic finish_tx(input logic [2:0] sts);
        @(negedge clk); tx_done = 1'b1; tx_sts = sts;
        @(negedge clk); tx_done = 1'b0; tx_sts = 3'd0;
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1; valid = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        tx_busy = 1'b0; tx_done = 1'b0; tx_sts = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_tx_start", 64'(tx_start), 64'd0);
        check("rst_baud", 64'(baud_cfg), 64'd0);
        rst = 1'b0;

        // Baud write gated by cfg_en.
        wr(8'h04, 32'h2);
        check("cfg_en_set", 64'(cfg_en), 64'd1);
        wr(8'h00, 32'h0042_0C06);
        wr(8'h04, 32'h0);
        check("baud_out", 64'(baud_cfg), 64'h42_0C06);
        wr(8'h00, 32'h0000_1234);
        rd_chk("baud_locked", 8'h00, 32'h0042_0C06);
        rd_chk("unaligned_rd", 8'h06, 32'h0);

        // Fixed priority: mbox0 then mbox2.
        wr_mbox(0, 32'h1234_5678, 32'h8, 32'hA0A0_0001, 32'hB0B0_0001);
        wr_mbox(1, 32'h0008_0001, 32'h2, 32'hA1A1_0001, 32'hB1B1_0001);
        wr_mbox(2, 32'h0010_0002, 32'h4, 32'h1122_3344, 32'hB2B2_0002);
        wr_mbox(3, 32'h0018_0003, 32'h1, 32'hA3A3_0003, 32'hB3B3_0003);
        bus(1'b1, 8'h48, 32'hFFFF_FFFF, 4'b0011, v);
        m_d1[2] = 32'h1122_FFFF;
        rd_chk("strobe_d1", 8'h48, m_d1[2]);
        launch_q.push_back(0); launch_q.push_back(2);
        wr(8'h10, 32'h5);
        wait_launch("fp_launch0");
        check("fp_dlc", 64'(tx_dlc), 64'd8);
        check("fp_data", tx_data, {m_d2[0], m_d1[0]});
        finish_tx(3'b001);
        rd_chk("irq_after0", 8'h0C, 32'h1);
        wait_launch("fp_launch2");
        finish_tx(3'b001);
        rd_chk("irq_after2", 8'h0C, 32'h5);
        rd_chk("pending_zero", 8'h10, 32'h0);
        rd_chk("ctrl_sts", 8'h08, 32'h0000_2100);

        // Round-robin from pointer 0, re-request 0 and 1 mid-sequence.
        launch_q.push_back(3);
        wr(8'h10, 32'h8);
        wait_launch("rr_prime3");
        finish_tx(3'b001);
        wr(8'h04, 32'h8);
        launch_q.push_back(0); launch_q.push_back(1); launch_q.push_back(2);
        launch_q.push_back(3); launch_q.push_back(0); launch_q.push_back(1);
        wr(8'h10, 32'hF);
        wait_launch("rr_l0"); finish_tx(3'b001);
        wait_launch("rr_l1"); finish_tx(3'b001);
        wr(8'h10, 32'h3);
        wait_launch("rr_l2"); finish_tx(3'b001);
        wait_launch("rr_l3"); finish_tx(3'b001);
        wait_launch("rr_l0b"); finish_tx(3'b001);
        wait_launch("rr_l1b"); finish_tx(3'b001);

        // Arbitration lost retry, then error status and irq latency.
        wr(8'h0C, 32'hFFFF);
        wr(8'h04, 32'h4);
        check("irq_clear", 64'(irq), 64'd0);
        launch_q.push_back(1); launch_q.push_back(1);
        wr(8'h10, 32'h2);
        wait_launch("arb_l1");
        finish_tx(3'b010);
        rd_chk("arb_pending", 8'h10, 32'h2);
        wait_launch("arb_relaunch");
        finish_tx(3'b100);
        check("irq_latency0", 64'(irq), 64'd0);
        @(negedge clk);
        check("irq_latency1", 64'(irq), 64'd1);
        rd_chk("err_bit9", 8'h0C, 32'h200);
        rd_chk("err_pending", 8'h10, 32'h0);

        // Protections while mbox0 is active.
        wr(8'h0C, 32'hFFFF);
        launch_q.push_back(0);
        wr(8'h10, 32'h1);
        wait_launch("prot_l0");
        wr(8'h28, 32'hDEAD_BEEF);
        check("prot_tx_data", tx_data, {m_d2[0], m_d1[0]});
        rd_chk("prot_mbox_rd", 8'h28, m_d1[0]);
        wr(8'h14, 32'h1);
        rd_chk("prot_abort", 8'h10, 32'h1);
        @(negedge clk);
        valid = 1'b1; we = 1'b1; addr = 8'h0C; wdata = 32'h1; wstrb = 4'hF;
        tx_done = 1'b1; tx_sts = 3'b001;
        @(negedge clk);
        check("w1c_race_ready", 64'(ready), 64'd1);
        valid = 1'b0; we = 1'b0; tx_done = 1'b0; tx_sts = 3'd0;
        rd_chk("w1c_race_irq", 8'h0C, 32'h1);
        rd_chk("w1c_race_pend", 8'h10, 32'h0);

        // Reset during WAIT_DONE.
        launch_q.push_back(2);
        wr(8'h10, 32'h4);
        wait_launch("rst_l2");
        check("irq_before_rst", 64'(irq), 64'd1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("mrst_tx_start", 64'(tx_start), 64'd0);
        check("mrst_irq", 64'(irq), 64'd0);
        check("mrst_ready", 64'(ready), 64'd0);
        check("mrst_sid", 64'(tx_sid), 64'd0);
        rst = 1'b0;
        rd_chk("mrst_ctrl", 8'h08, 32'h0);
        rd_chk("mrst_irq_sts", 8'h0C, 32'h0);
        rd_chk("mrst_pending", 8'h10, 32'h0);
        repeat (10) @(negedge clk);
        check("no_extra_launch", 64'(obs_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
